// File: rtl/moore_stream_ctrl.sv
// Sequencing controller for serial Moore sequence detectors.
// Captures a test word on start, clears the detector, shifts the word out
// MSB-first, counts cycles where the detector output is high (saturating),
// then pulses done for one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; hit_cnt holds the last result
// S_CLEAR | one-cycle synchronous clear to the detector, x_out = 0
// S_SHIFT | word shifted out MSB-first, one bit per cycle, det_in counted
// S_DRAIN | x_out = 0 for DRAIN cycles, det_in still counted
// S_DONE  | one-cycle done pulse
module moore_stream_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int DRAIN = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           det_in,
    output logic                           x_out,
    output logic                           det_clr,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(WIDTH+1)-1:0]     bit_idx,
    output logic [CNT_W-1:0]               hit_cnt
);

    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Drain timer is a down-counter; it is loaded with DRAIN-1 while shifting
    // so that reaching zero marks the last drain cycle.
    localparam logic [2:0]    DRAIN_LOAD = 3'((DRAIN > 0) ? (DRAIN - 1) : 0);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [2:0]       drain_cnt;
    logic             counting;

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (bit_idx == LAST_BIT)
                    state_nxt = (DRAIN == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: if (drain_cnt == 3'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Shift register, bit index and drain timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg      <= '0;
            bit_idx   <= '0;
            drain_cnt <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sreg    <= data_in;
                        bit_idx <= '0;
                    end
                end
                S_SHIFT: begin
                    sreg      <= {sreg[WIDTH-2:0], 1'b0};
                    bit_idx   <= bit_idx + BW'(1);
                    drain_cnt <= DRAIN_LOAD;
                end
                S_DRAIN: begin
                    if (drain_cnt != 3'd0)
                        drain_cnt <= drain_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign counting = (state == S_SHIFT) || (state == S_DRAIN);

    // Saturating hit counter; every high cycle counts, so overlapping matches add up
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hit_cnt <= '0;
        else if (state == S_IDLE && start)
            hit_cnt <= '0;
        else if (counting && det_in && (hit_cnt != {CNT_W{1'b1}}))
            hit_cnt <= hit_cnt + CNT_W'(1);
    end

    // Moore outputs decoded from the registered state
    assign x_out   = (state == S_SHIFT) && sreg[WIDTH-1];
    assign det_clr = (state == S_CLEAR);
    assign busy    = (state == S_CLEAR) || counting;
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_moore_stream_ctrl.sv
// Bench for moore_stream_ctrl: randomized runs, a scoreboard of expected
// stream/hit results, and a negedge monitor that checks each done pulse.
module tb_moore_stream_ctrl;

    localparam int W = 16;
    localparam int D = 2;
    localparam int BW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  data_in;
    logic          det_in;
    logic          x_out, det_clr, busy, done;
    logic [BW-1:0] bit_idx;
    logic [4:0]    hit_cnt;
    logic          x_out4, det_clr4, busy4, done4;
    logic [BW-1:0] bit_idx4;
    logic [3:0]    hit_cnt4;

    moore_stream_ctrl #(.WIDTH(W), .CNT_W(5), .DRAIN(D)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .det_in(det_in),
        .x_out(x_out), .det_clr(det_clr), .busy(busy), .done(done),
        .bit_idx(bit_idx), .hit_cnt(hit_cnt)
    );

    moore_stream_ctrl #(.WIDTH(W), .CNT_W(4), .DRAIN(D)) dut4 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .det_in(det_in),
        .x_out(x_out4), .det_clr(det_clr4), .busy(busy4), .done(done4),
        .bit_idx(bit_idx4), .hit_cnt(hit_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] data;
        int           hits;
    } exp_t;
    exp_t sb[$];

    // det_in source: 0 const, 1 const, closed-loop "11" detector, random pattern
    int   mode_r = 0;
    logic det_pat = 1'b0;
    logic [1:0] h;

    always @(posedge clk or posedge rst) begin
        if (rst)          h <= 2'b00;
        else if (det_clr) h <= 2'b00;
        else              h <= {h[0], x_out};
    end

    assign det_in = (mode_r == 2) ? (h[1] & h[0]) : det_pat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Reference: stream = word MSB-first then D zeros; counted cycle j (1..W+D)
    // sees the detector output after it has absorbed stream bits 0..j-2.
    function automatic int model_hits(input logic [W-1:0] d, input int mode,
                                      input logic [W+D+2:0] pat);
        logic s [W+D];
        int n = 0;
        for (int i = 0; i < W + D; i++)
            s[i] = (i < W) ? d[W-1-i] : 1'b0;
        for (int j = 1; j <= W + D; j++) begin
            case (mode)
                0:       n += 0;
                1:       n += 1;
                2:       n += (j >= 3 && s[j-3] && s[j-2]) ? 1 : 0;
                default: n += pat[j+1] ? 1 : 0;
            endcase
        end
        return n;
    endfunction

    // Monitor: tracks each run from busy rise, pops the scoreboard on done
    int cyc = 0;
    int run_start = 0;
    logic prev_busy = 1'b0;
    logic [W-1:0] cap = '0;

    always @(negedge clk) begin
        exp_t e;
        int off;
        cyc++;
        if (!rst) begin
            if (busy && !prev_busy) begin
                run_start = cyc;
                cap = '0;
                chk("clear_cycle", {det_clr, x_out}, 2'b10);
            end else if (busy) begin
                off = cyc - run_start;
                if (off <= W) cap = {cap[W-2:0], x_out};
                else          chk("drain_x_low", x_out, 1'b0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("x_stream", cap, e.data);
                    chk("hit_cnt", hit_cnt, sat(e.hits, 31));
                    chk("hit_cnt_sat4", hit_cnt4, sat(e.hits, 15));
                    chk("done_latency", cyc - run_start, W + D + 1);
                    chk("bit_idx_end", bit_idx, W);
                    chk("busy_in_done", busy, 1'b0);
                end
            end
        end
        prev_busy = busy;
    end

    // One run: start accepted at the edge after the first negedge;
    // c counts cycles after that edge. busy_at / rst_at are c values (0 = off).
    task automatic run(input logic [W-1:0] d, input int mode, input int busy_at, input int rst_at);
        logic [W+D+2:0] pat;
        exp_t e;
        pat = '0;
        for (int c = 0; c <= W + D + 2; c++) pat[c] = 1'($urandom_range(0, 1));
        e.data = d;
        e.hits = model_hits(d, mode, pat);
        sb.push_back(e);
        mode_r = mode;
        @(negedge clk);
        data_in = d;
        start = 1'b1;
        det_pat = 1'b0;
        for (int c = 1; c <= W + D + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                data_in = W'($urandom);
            end
            if (busy_at != 0 && c == busy_at) begin
                start = 1'b1;
                data_in = W'($urandom);
            end
            if (busy_at != 0 && c == busy_at + 1) start = 1'b0;
            det_pat = (mode == 3) ? pat[c] : (mode == 1);
            if (rst_at != 0 && c == rst_at) begin
                #2;
                chk("bit_idx_before_rst", bit_idx, 7);
                rst = 1'b1;
                #1;
                chk("rst_mid_outputs", {x_out, det_clr, busy, done, bit_idx, hit_cnt}, 0);
                void'(sb.pop_back());
                @(negedge clk);
                #2 rst = 1'b0;
                det_pat = 1'b0;
                return;
            end
        end
        det_pat = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        data_in = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", {x_out, det_clr, busy, done, bit_idx, hit_cnt}, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_outputs", {x_out, det_clr, busy, done, bit_idx, hit_cnt}, 0);
        end

        run(16'hA5C3, 0, 0, 0);
        run(16'hA5C3, 1, 0, 0);
        run(16'hF000, 2, 0, 0);
        run(W'($urandom), 3, 7, 0);
        run(W'($urandom), 3, 0, 9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", {done, busy}, 0);
        end
        run(W'($urandom), 2, 0, 0);
        for (int i = 0; i < 20; i++)
            run(W'($urandom), int'($urandom_range(0, 3)), 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/moore_stream_ctrl.md
# moore_stream_ctrl

Sequencing controller for the lab's serial Moore sequence detectors. It accepts a parallel test word on a start strobe and clears the attached detector. It then shifts the word out MSB-first on the detector's serial input, samples the detector's Moore output, counts detection cycles and signals completion with a one-cycle done pulse. It sits between the board-level stimulus logic (switches/buttons) and a detector instance such as a 1-bit or 2-bit Moore recognizer.

## Interface
- WIDTH, 16, length of test word in bits (2..32)
- CNT_W, 5, width of hit counter; counter saturates at 2^CNT_W-1
- DRAIN, 2, extra cycles after last bit during which det_in is still sampled (0..7)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to run a test word; accepted only in IDLE
- data_in  in  WIDTH  test word, captured on the accepting edge
- det_in  in  1  detector Moore output
- x_out  out  1  serial bit to detector input (detector's x_in)
- det_clr  out  1  one-cycle synchronous clear to detector
- busy  out  1  high in CLEAR, SHIFT, DRAIN
- done  out  1  one-cycle pulse in DONE
- bit_idx  out  $clog2(WIDTH+1)  number of bits already shifted out in current run
- hit_cnt  out  CNT_W  number of counted cycles with det_in=1

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE (binary encoded, registered).
- IDLE: start=1 -> capture data_in into shift register, clear hit_cnt and bit_idx, go CLEAR. start=0 -> stay; hit_cnt holds the last result.
- CLEAR: det_clr=1, x_out=0 for exactly one cycle -> SHIFT. det_in is not counted.
- SHIFT: x_out = shift register MSB (combinational from register). Each edge shifts left by one with zero fill and increments bit_idx. After WIDTH cycles (bit_idx reaches WIDTH) go DRAIN, or DONE if DRAIN=0.
- DRAIN: x_out=0 for DRAIN cycles -> DONE.
- DONE: done=1 for one cycle -> IDLE. det_in is not counted.
- Counting: on every edge while in SHIFT or DRAIN, det_in=1 increments hit_cnt. It saturates at all-ones with no wrap. Consecutive high cycles count individually, so overlapping detections are counted.
- start is ignored in CLEAR/SHIFT/DRAIN/DONE; data_in changes there have no effect.
- Reset (any time, including mid-run) takes effect immediately:
  - state=IDLE
  - shift register, bit_idx and hit_cnt cleared to 0
  - x_out=0, det_clr=0, busy=0, done=0
- Reset values of all outputs: 0.

## Timing
- start sampled high at edge E0 -> CLEAR during cycle after E0.
- SHIFT occupies the next WIDTH cycles. Bit i (MSB = i=0) is on x_out in SHIFT cycle i+1.
- DRAIN occupies the next DRAIN cycles.
- done is high in cycle WIDTH+DRAIN+2 after E0. Next start is accepted at the edge ending DONE+1 (first IDLE cycle).
- busy rises the cycle after E0 and falls when DONE is entered.
- hit_cnt is final and stable from the DONE cycle until the next accepted start.

## Test plan
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately. Release, start=0 for 5 cycles -> state stays IDLE, outputs 0.
- Basic run (WIDTH=16, DRAIN=2, det_in=0): start with data_in=16'hA5C3.
  - det_clr pulses 1 cycle; x_out then carries 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - done pulses exactly 20 cycles after the accepting edge; hit_cnt=0.
- Counting: det_in tied 1 -> hit_cnt=18 (16 SHIFT + 2 DRAIN; CLEAR/DONE excluded). Repeat with CNT_W=4 -> hit_cnt saturates at 15.
- Closed loop with a 2-bit Moore "11" detector: data_in=16'hF000 -> x_out sequence and hit_cnt match a reference model (overlapping detections counted per cycle).
- Start while busy: pulse start with a new data_in at SHIFT bit 5 -> ignored. x_out continues the original word, and only one done pulse is produced.
- Reset mid-run: assert rst during SHIFT at bit_idx=7 -> state IDLE, x_out=0, bit_idx=0, hit_cnt=0, no done pulse. A subsequent start runs a complete fresh sequence.
